// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and limits for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_ILLEGAL
    } op_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = 2;

    // Both enables at once, or any address bit above the RAM range, is rejected.
    function automatic op_t decode_op(input logic re, input logic we, input logic addr_high_nz);
        if ((re && we) || addr_high_nz) begin
            return OP_ILLEGAL;
        end
        return re ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous 32-bit RAM with registered read data
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // Read data only moves on an enabled read, so it doubles as the held response word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency responder for the CPU data-memory interface
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wrt_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        wr_done,
    output logic        err,
    output logic        stall
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_latency_check
        $error("dmem_responder: LATENCY %0d outside %0d..%0d", LATENCY, LAT_MIN, LAT_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    op_t                   op_q;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  req;
    logic                  last_busy;

    assign req       = re | we;
    assign last_busy = (state == BUSY) && (cnt == '0);
    assign stall     = !rst && (((state == IDLE) && req) || (state == BUSY));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            data_q   <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= last_busy && (op_q == OP_READ);
            wr_done  <= last_busy && (op_q == OP_WRITE);
            err      <= last_busy && (op_q == OP_ILLEGAL);
            if ((state == IDLE) && req) begin
                op_q   <= decode_op(re, we, |addr[31:DEPTH_LOG2]);
                addr_q <= addr[DEPTH_LOG2-1:0];
                data_q <= wrt_data;
                cnt    <= CNT_INIT;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // RAM is touched only on the BUSY->RESP edge, so a reset earlier aborts cleanly.
    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .rd_en (last_busy && (op_q == OP_READ) && !rst),
        .wr_en (last_busy && (op_q == OP_WRITE) && !rst),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [31:0] addr, wrt_data;
    logic [31:0] rd_data;
    logic        rd_valid, wr_done, err, stall;

    logic        re_s, we_s;
    logic [31:0] addr_s, data_s;
    logic [31:0] rd_data1, rd_data4;
    logic        rd_valid1, wr_done1, err1, stall1;
    logic        rd_valid4, wr_done4, err4, stall4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wrt_data(wrt_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done), .err(err), .stall(stall)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .re(re_s), .we(we_s), .addr(addr_s), .wrt_data(data_s),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .wr_done(wr_done1), .err(err1), .stall(stall1)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .re(re_s), .we(we_s), .addr(addr_s), .wrt_data(data_s),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .wr_done(wr_done4), .err(err4), .stall(stall4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until the response pulse, as the MEM stage would; lat=-1 on timeout.
    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int stalls, output logic [2:0] pulses, output int resp_cyc);
        re = r; we = w; addr = a; wrt_data = d;
        lat = -1; stalls = 0; pulses = 3'b000; resp_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (rd_valid || wr_done || err) begin
                lat = k;
                pulses = {rd_valid, wr_done, err};
                resp_cyc = cyc;
            end
            tick();
            if (lat >= 0) break;
        end
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, rc, rc1;
        int l1, l4, s1, s4;
        logic [2:0] p;

        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wrt_data = '0;
        re_s = 1'b0; we_s = 1'b0; addr_s = '0; data_s = '0;
        repeat (2) tick();
        re = 1'b1;
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_wr_done", 32'(wr_done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        re = 1'b0;
        tick();
        rst = 1'b0;

        req(1'b0, 1'b1, 32'd0, 32'h0000_00AA, lat, st, p, rc);
        req(1'b0, 1'b1, 32'd6, 32'h0000_1234, lat, st, p, rc);
        req(1'b0, 1'b1, 32'd7, 32'h0000_0077, lat, st, p, rc);
        req(1'b0, 1'b1, 32'd9, 32'h0000_0099, lat, st, p, rc);

        req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, st, p, rc);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_stall_cycles", 32'(st), 32'd3);
        check("wr_pulses", 32'(p), 32'b010);
        req(1'b1, 1'b0, 32'd5, 32'd0, lat, st, p, rc);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_pulses", 32'(p), 32'b100);
        check("rd_data_5", rd_data, 32'hDEAD_BEEF);

        req(1'b1, 1'b0, 32'd5, 32'd0, lat, st, p, rc1);
        req(1'b1, 1'b0, 32'd6, 32'd0, lat, st, p, rc);
        check("b2b_spacing", 32'(rc - rc1), 32'd4);
        check("b2b_rd_data_6", rd_data, 32'h0000_1234);
        repeat (3) tick();
        check("rd_data_held", rd_data, 32'h0000_1234);

        req(1'b1, 1'b1, 32'd7, 32'h0000_0BAD, lat, st, p, rc);
        check("illegal_pulses", 32'(p), 32'b001);
        check("illegal_rd_data_kept", rd_data, 32'h0000_1234);
        req(1'b1, 1'b0, 32'd7, 32'd0, lat, st, p, rc);
        check("illegal_ram7_kept", rd_data, 32'h0000_0077);

        req(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, lat, st, p, rc);
        check("oor_pulses", 32'(p), 32'b001);
        req(1'b1, 1'b0, 32'd0, 32'd0, lat, st, p, rc);
        check("oor_ram0_kept", rd_data, 32'h0000_00AA);

        we = 1'b1; addr = 32'd9; wrt_data = 32'hA5A5_A5A5;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall_in_rst", 32'(stall), 32'd0);
        tick();
        rst = 1'b0; we = 1'b0;
        @(negedge clk);
        check("midrst_stall_after", 32'(stall), 32'd0);
        check("midrst_no_wr_done", 32'(wr_done), 32'd0);
        repeat (3) begin
            tick();
            check("midrst_no_late_wr_done", 32'(wr_done), 32'd0);
        end
        req(1'b1, 1'b0, 32'd9, 32'd0, lat, st, p, rc);
        check("midrst_idle_latency", 32'(lat), 32'd3);
        check("midrst_ram9_kept", rd_data, 32'h0000_0099);

        we_s = 1'b1; addr_s = 32'd3; data_s = 32'h0000_0033;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tick();
            if (wr_done4) break;
        end
        we_s = 1'b0;
        repeat (3) tick();

        re_s = 1'b1;
        l1 = -1; l4 = -1; s1 = 0; s4 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (l1 < 0) begin
                if (stall1) s1++;
                if (rd_valid1) l1 = k;
            end
            if (l4 < 0) begin
                if (stall4) s4++;
                if (rd_valid4) l4 = k;
            end
            tick();
            if (l1 >= 0 && l4 >= 0) break;
        end
        re_s = 1'b0;
        check("lat1_rd_latency", 32'(l1), 32'd2);
        check("lat1_stall_cycles", 32'(s1), 32'd2);
        check("lat1_rd_data", rd_data1, 32'h0000_0033);
        check("lat4_rd_latency", 32'(l4), 32'd5);
        check("lat4_stall_cycles", 32'(s4), 32'd5);
        check("lat4_rd_data", rd_data4, 32'h0000_0033);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
